// File: rtl/cam_pkg.sv
// Shared definitions for the hashed CAM controller: op/status codes, FSM states
// and the slot field layout (valid bit, key, result, optional timestamp).
package cam_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_MISS   = 2'b01,
    ST_FULL   = 2'b10,
    ST_BAD_OP = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CMP  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  localparam int VLD_BIT = 0;
  localparam int KEY_LSB = 1;

  // Result and timestamp offsets move with the key width, so they are derived.
  function automatic int resLsb(input int dw);
    return KEY_LSB + dw;
  endfunction

  function automatic int timLsb(input int dw, input int rw);
    return KEY_LSB + dw + rw;
  endfunction

endpackage

// File: rtl/multi_hash_cam_ctrl_hash.sv
// Combinational hash pair: XOR-fold of the key in HW-bit chunks (table A)
// and the same fold of the bit-reversed key (table B).
module cam_hash
  import cam_pkg::*;
#(
  parameter int DW = 19,
  parameter int HW = 6
) (
  input  logic [DW-1:0] key_i,
  output logic [HW-1:0] hashA_o,
  output logic [HW-1:0] hashB_o
);

  localparam int NCH = (DW + HW - 1) / HW;

  logic [NCH*HW-1:0] padA;
  logic [NCH*HW-1:0] padB;

  // The top chunk is zero-padded when DW is not a multiple of HW.
  always_comb begin
    padA = '0;
    padB = '0;
    for (int i = 0; i < DW; i++) begin
      padA[i] = key_i[i];
      padB[i] = key_i[DW-1-i];
    end
    hashA_o = '0;
    hashB_o = '0;
    for (int c = 0; c < NCH; c++) begin
      hashA_o = hashA_o ^ padA[c*HW +: HW];
      hashB_o = hashB_o ^ padB[c*HW +: HW];
    end
  end

endmodule

// File: rtl/multi_hash_cam_ctrl.sv
// Request-side controller for a two-table, SN-way hashed CAM: reads both lines,
// compares slots, optionally rewrites one slot, and answers on a valid/ready channel.
module multi_hash_cam_ctrl
  import cam_pkg::*;
#(
  parameter  int SN = 4,
  parameter  int HW = 6,
  parameter  int DW = 19,
  parameter  int RW = 20,
  parameter  int TW = 0,
  localparam int SW = TW + RW + DW + 1,
  localparam int LW = SW * SN
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_key,
  input  logic [RW-1:0] req_result,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_hit,
  output logic [RW-1:0] rsp_result,
  output logic [1:0]    rsp_status,

  output logic [HW-1:0] rama_addra_o,
  input  logic [LW-1:0] rama_douta_i,
  output logic          rama_web_o,
  output logic [HW-1:0] rama_addrb_o,
  output logic [LW-1:0] rama_dinb_o,

  output logic [HW-1:0] ramb_addra_o,
  input  logic [LW-1:0] ramb_douta_i,
  output logic          ramb_web_o,
  output logic [HW-1:0] ramb_addrb_o,
  output logic [LW-1:0] ramb_dinb_o
);

  localparam int RES_LSB = resLsb(DW);
  localparam int TIM_LSB = timLsb(DW, RW);
  localparam int TWE     = (TW > 0) ? TW : 1;
  localparam int SIW     = (SN > 1) ? $clog2(SN) : 1;

  state_e          state_q;
  op_e             op_q;
  logic [DW-1:0]   key_q;
  logic [RW-1:0]   result_q;
  logic [HW-1:0]   hashA_q;
  logic [HW-1:0]   hashB_q;
  logic [TWE-1:0]  ts_q;

  logic            reqReady_q;
  logic            rspValid_q;
  logic            rspHit_q;
  logic [RW-1:0]   rspResult_q;
  logic [1:0]      rspStatus_q;

  logic            webA_q;
  logic            webB_q;
  logic [HW-1:0]   addrbA_q;
  logic [HW-1:0]   addrbB_q;
  logic [LW-1:0]   dinbA_q;
  logic [LW-1:0]   dinbB_q;

  logic [HW-1:0]   hashA;
  logic [HW-1:0]   hashB;

  cam_hash #(
    .DW (DW),
    .HW (HW)
  ) uHash (
    .key_i   (req_key),
    .hashA_o (hashA),
    .hashB_o (hashB)
  );

  function automatic logic [SIW-1:0] lowestIdx(input logic [SN-1:0] vec);
    lowestIdx = '0;
    for (int i = SN - 1; i >= 0; i--) begin
      if (vec[i]) lowestIdx = SIW'(i);
    end
  endfunction

  logic [SN-1:0][SW-1:0] slotsA;
  logic [SN-1:0][SW-1:0] slotsB;
  logic [SN-1:0]         matchA;
  logic [SN-1:0]         matchB;
  logic [SN-1:0]         freeA;
  logic [SN-1:0]         freeB;

  assign slotsA = rama_douta_i;
  assign slotsB = ramb_douta_i;

  always_comb begin
    matchA = '0;
    matchB = '0;
    freeA  = '0;
    freeB  = '0;
    for (int i = 0; i < SN; i++) begin
      matchA[i] = slotsA[i][VLD_BIT] && (slotsA[i][KEY_LSB +: DW] == key_q);
      matchB[i] = slotsB[i][VLD_BIT] && (slotsB[i][KEY_LSB +: DW] == key_q);
      freeA[i]  = !slotsA[i][VLD_BIT];
      freeB[i]  = !slotsB[i][VLD_BIT];
    end
  end

  logic                  hit_d;
  logic                  useB_d;
  logic [SIW-1:0]        slot_d;
  logic                  doWrite_d;
  status_e               status_d;
  logic [RW-1:0]         foundRes_d;
  logic [SN-1:0][SW-1:0] baseLine;
  logic [SN-1:0][SW-1:0] newLine_d;
  logic [SW-1:0]         curSlot;
  logic [SW-1:0]         newSlot;

  // Slot selection priority: match in A, match in B, free in A, free in B.
  always_comb begin
    hit_d      = (|matchA) || (|matchB);
    useB_d     = 1'b0;
    slot_d     = '0;
    doWrite_d  = 1'b0;
    status_d   = ST_OK;
    foundRes_d = '0;
    if (|matchA) begin
      slot_d = lowestIdx(matchA);
    end else if (|matchB) begin
      useB_d = 1'b1;
      slot_d = lowestIdx(matchB);
    end else if (|freeA) begin
      slot_d = lowestIdx(freeA);
    end else if (|freeB) begin
      useB_d = 1'b1;
      slot_d = lowestIdx(freeB);
    end
    baseLine = useB_d ? slotsB : slotsA;
    curSlot  = baseLine[slot_d];
    newSlot  = curSlot;
    if (hit_d) foundRes_d = curSlot[RES_LSB +: RW];

    case (op_q)
      OP_LOOKUP: status_d = hit_d ? ST_OK : ST_MISS;
      OP_INSERT: begin
        if (hit_d) begin
          newSlot[RES_LSB +: RW] = result_q;
          doWrite_d = 1'b1;
        end else if ((|freeA) || (|freeB)) begin
          newSlot                = '0;
          newSlot[VLD_BIT]       = 1'b1;
          newSlot[KEY_LSB +: DW] = key_q;
          newSlot[RES_LSB +: RW] = result_q;
          doWrite_d = 1'b1;
        end else begin
          status_d = ST_FULL;
        end
        for (int b = 0; b < TW; b++) newSlot[TIM_LSB + b] = ts_q[b];
      end
      OP_DELETE: begin
        if (hit_d) begin
          newSlot[VLD_BIT] = 1'b0;
          doWrite_d = 1'b1;
        end else begin
          status_d = ST_MISS;
        end
      end
      default: status_d = ST_BAD_OP;
    endcase

    newLine_d         = baseLine;
    newLine_d[slot_d] = newSlot;
  end

  // Single-operation FSM; all client and RAM-write outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOOKUP;
      key_q       <= '0;
      result_q    <= '0;
      hashA_q     <= '0;
      hashB_q     <= '0;
      ts_q        <= '0;
      reqReady_q  <= 1'b1;
      rspValid_q  <= 1'b0;
      rspHit_q    <= 1'b0;
      rspResult_q <= '0;
      rspStatus_q <= '0;
      webA_q      <= 1'b0;
      webB_q      <= 1'b0;
      addrbA_q    <= '0;
      addrbB_q    <= '0;
      dinbA_q     <= '0;
      dinbB_q     <= '0;
    end else begin
      ts_q   <= ts_q + TWE'(1);
      webA_q <= 1'b0;
      webB_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && reqReady_q) begin
            reqReady_q <= 1'b0;
            op_q       <= op_e'(req_op);
            key_q      <= req_key;
            result_q   <= req_result;
            if (op_e'(req_op) == OP_RSVD) begin
              rspValid_q  <= 1'b1;
              rspHit_q    <= 1'b0;
              rspResult_q <= '0;
              rspStatus_q <= ST_BAD_OP;
              state_q     <= S_RSP;
            end else begin
              hashA_q <= hashA;
              hashB_q <= hashB;
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_CMP;
        S_CMP: begin
          rspHit_q    <= hit_d;
          rspResult_q <= foundRes_d;
          rspStatus_q <= status_d;
          if (doWrite_d) begin
            if (useB_d) begin
              webB_q   <= 1'b1;
              addrbB_q <= hashB_q;
              dinbB_q  <= newLine_d;
            end else begin
              webA_q   <= 1'b1;
              addrbA_q <= hashA_q;
              dinbA_q  <= newLine_d;
            end
            state_q <= S_WR;
          end else begin
            rspValid_q <= 1'b1;
            state_q    <= S_RSP;
          end
        end
        S_WR: begin
          rspValid_q <= 1'b1;
          state_q    <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = reqReady_q;
  assign rsp_valid    = rspValid_q;
  assign rsp_hit      = rspHit_q;
  assign rsp_result   = rspResult_q;
  assign rsp_status   = rspStatus_q;

  assign rama_addra_o = hashA_q;
  assign ramb_addra_o = hashB_q;
  assign rama_web_o   = webA_q;
  assign ramb_web_o   = webB_q;
  assign rama_addrb_o = addrbA_q;
  assign ramb_addrb_o = addrbB_q;
  assign rama_dinb_o  = dinbA_q;
  assign ramb_dinb_o  = dinbB_q;

endmodule

// File: tb/tb_multi_hash_cam_ctrl.sv
// Directed bench for multi_hash_cam_ctrl with two zero-initialised line RAM models
// (1-cycle read latency) and a table of operations with hand-computed responses.
module tb_multi_hash_cam_ctrl;

  localparam int SN = 4;
  localparam int HW = 6;
  localparam int DW = 19;
  localparam int RW = 20;
  localparam int TW = 0;
  localparam int SW = TW + RW + DW + 1;
  localparam int LW = SW * SN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [DW-1:0] req_key = '0;
  logic [RW-1:0] req_result = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit;
  logic [RW-1:0] rsp_result;
  logic [1:0]    rsp_status;
  logic [HW-1:0] rama_addra, rama_addrb, ramb_addra, ramb_addrb;
  logic [LW-1:0] rama_douta, rama_dinb, ramb_douta, ramb_dinb;
  logic          rama_web, ramb_web;

  logic          memClear = 1'b1;
  logic [LW-1:0] memA [64];
  logic [LW-1:0] memB [64];

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  multi_hash_cam_ctrl #(
    .SN (SN), .HW (HW), .DW (DW), .RW (RW), .TW (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_key      (req_key),
    .req_result   (req_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hit      (rsp_hit),
    .rsp_result   (rsp_result),
    .rsp_status   (rsp_status),
    .rama_addra_o (rama_addra),
    .rama_douta_i (rama_douta),
    .rama_web_o   (rama_web),
    .rama_addrb_o (rama_addrb),
    .rama_dinb_o  (rama_dinb),
    .ramb_addra_o (ramb_addra),
    .ramb_douta_i (ramb_douta),
    .ramb_web_o   (ramb_web),
    .ramb_addrb_o (ramb_addrb),
    .ramb_dinb_o  (ramb_dinb)
  );

  // Line RAM models: synchronous read, write through port B.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 64; i++) begin
        memA[i] <= '0;
        memB[i] <= '0;
      end
      rama_douta <= '0;
      ramb_douta <= '0;
    end else begin
      rama_douta <= memA[rama_addra];
      ramb_douta <= memB[ramb_addra];
      if (rama_web) memA[rama_addrb] <= rama_dinb;
      if (ramb_web) memB[ramb_addrb] <= ramb_dinb;
    end
  end

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] key;
    logic [RW-1:0] res;
    logic          expHit;
    logic [1:0]    expStatus;
    logic [RW-1:0] expRes;
    bit            chkRes;
    int            expWebA;
    int            expWebB;
    int            lat;
  } vec_t;

  vec_t vecs [18];

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [SW-1:0] slotVal(input logic [RW-1:0] res, input logic [DW-1:0] key, input logic vld);
    return {res, key, vld};
  endfunction

  function automatic logic [SW-1:0] slotOf(input logic [LW-1:0] line, input int idx);
    return line[idx*SW +: SW];
  endfunction

  task automatic applyStimulus(input vec_t v);
    int  cyc;
    int  webA;
    int  webB;
    bit  seen;
    @(negedge clk);
    checkOutput("req_ready before issue", req_ready, 1);
    req_valid  = 1'b1;
    req_op     = v.op;
    req_key    = v.key;
    req_result = v.res;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; webA = 0; webB = 0; seen = 0;
    while (!seen && cyc <= 12) begin
      if (rama_web) webA++;
      if (ramb_web) webB++;
      if (rsp_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checkOutput("rsp latency", cyc, v.lat);
    checkOutput("rsp_hit", rsp_hit, v.expHit);
    checkOutput("rsp_status", rsp_status, v.expStatus);
    if (v.chkRes) checkOutput("rsp_result", rsp_result, v.expRes);
    checkOutput("ram A web pulses", webA, v.expWebA);
    checkOutput("ram B web pulses", webB, v.expWebB);
    checkOutput("req_ready while busy", req_ready, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid after handshake", rsp_valid, 0);
    checkOutput("req_ready after handshake", req_ready, 1);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{2'b00, 19'h00001, 20'h00000, 1'b0, 2'b01, 20'h00000, 1, 0, 0, 3};
    vecs[1]  = '{2'b01, 19'h00001, 20'hABCDE, 1'b0, 2'b00, 20'h00000, 1, 1, 0, 4};
    vecs[2]  = '{2'b00, 19'h00001, 20'h00000, 1'b1, 2'b00, 20'hABCDE, 1, 0, 0, 3};
    vecs[3]  = '{2'b01, 19'h00040, 20'h00002, 1'b0, 2'b00, 20'h00000, 1, 1, 0, 4};
    vecs[4]  = '{2'b01, 19'h01000, 20'h00003, 1'b0, 2'b00, 20'h00000, 1, 1, 0, 4};
    vecs[5]  = '{2'b01, 19'h40000, 20'h00004, 1'b0, 2'b00, 20'h00000, 1, 1, 0, 4};
    vecs[6]  = '{2'b01, 19'h01041, 20'h00005, 1'b0, 2'b00, 20'h00000, 1, 0, 1, 4};
    vecs[7]  = '{2'b01, 19'h40041, 20'h00006, 1'b0, 2'b00, 20'h00000, 1, 0, 1, 4};
    vecs[8]  = '{2'b01, 19'h41001, 20'h00007, 1'b0, 2'b00, 20'h00000, 1, 0, 1, 4};
    vecs[9]  = '{2'b01, 19'h41040, 20'h00008, 1'b0, 2'b00, 20'h00000, 1, 0, 1, 4};
    vecs[10] = '{2'b01, 19'h00083, 20'h00009, 1'b0, 2'b10, 20'h00000, 1, 0, 0, 3};
    vecs[11] = '{2'b00, 19'h41040, 20'h00000, 1'b1, 2'b00, 20'h00008, 1, 0, 0, 3};
    vecs[12] = '{2'b01, 19'h00040, 20'h12345, 1'b1, 2'b00, 20'h00000, 0, 1, 0, 4};
    vecs[13] = '{2'b00, 19'h00040, 20'h00000, 1'b1, 2'b00, 20'h12345, 1, 0, 0, 3};
    vecs[14] = '{2'b10, 19'h01000, 20'h00000, 1'b1, 2'b00, 20'h00000, 0, 1, 0, 4};
    vecs[15] = '{2'b10, 19'h01000, 20'h00000, 1'b0, 2'b01, 20'h00000, 1, 0, 0, 3};
    vecs[16] = '{2'b00, 19'h01000, 20'h00000, 1'b0, 2'b01, 20'h00000, 1, 0, 0, 3};
    vecs[17] = '{2'b01, 19'h00083, 20'h0000A, 1'b0, 2'b00, 20'h00000, 1, 1, 0, 4};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_hit", rsp_hit, 0);
    checkOutput("reset rsp_result", rsp_result, 0);
    checkOutput("reset rsp_status", rsp_status, 0);
    checkOutput("reset webs", {rama_web, ramb_web}, 0);
    checkOutput("reset addresses", {rama_addra, rama_addrb, ramb_addra, ramb_addrb}, 0);
    checkOutput("reset dinb A", rama_dinb, 0);
    checkOutput("reset dinb B", ramb_dinb, 0);
    @(negedge clk);
    rst = 1'b0;
    memClear = 1'b0;

    for (int i = 0; i <= 14; i++) applyStimulus(vecs[i]);
    checkOutput("A1 slot0 after inserts", slotOf(memA[1], 0), slotVal(20'hABCDE, 19'h00001, 1'b1));
    checkOutput("A1 slot1 result updated", slotOf(memA[1], 1), slotVal(20'h12345, 19'h00040, 1'b1));
    checkOutput("A1 slot2 deleted", slotOf(memA[1], 2), slotVal(20'h00003, 19'h01000, 1'b0));
    checkOutput("B1 slot0", slotOf(memB[1], 0), slotVal(20'h00005, 19'h01041, 1'b1));

    for (int i = 15; i <= 17; i++) applyStimulus(vecs[i]);
    checkOutput("A1 slot2 reused", slotOf(memA[1], 2), slotVal(20'h0000A, 19'h00083, 1'b1));
    checkOutput("A1 slot3", slotOf(memA[1], 3), slotVal(20'h00004, 19'h40000, 1'b1));
    checkOutput("B1 slot3", slotOf(memB[1], 3), slotVal(20'h00008, 19'h41040, 1'b1));
    checkOutput("A0 untouched", memA[0], 0);

    // Reserved op answers one cycle after accept and holds while rsp_ready is low.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_key   = 19'h00001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bad_op rsp_valid at T+1", rsp_valid, 1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bad_op status held", rsp_status, 2'b11);
      checkOutput("bad_op hit/result held", {rsp_hit, rsp_result}, 0);
      checkOutput("bad_op valid held", rsp_valid, 1);
      checkOutput("bad_op req_ready low", req_ready, 0);
      checkOutput("bad_op no ram write", {rama_web, ramb_web}, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("bad_op handshake done", {rsp_valid, req_ready}, 2'b01);

    // Reset asserted while an INSERT is in its write cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = 2'b01;
    req_key    = 19'h00100;
    req_result = 20'h55555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("web A in WR cycle", {rama_web, ramb_web}, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort web", {rama_web, ramb_web}, 0);
    checkOutput("abort rsp", {rsp_valid, rsp_hit, rsp_result, rsp_status}, 0);
    checkOutput("abort req_ready", req_ready, 1);
    checkOutput("abort addresses", {rama_addra, rama_addrb, ramb_addra, ramb_addrb}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("no write after abort", {rama_web, ramb_web, rsp_valid}, 0);
    end
    v = '{2'b00, 19'h00001, 20'h00000, 1'b1, 2'b00, 20'hABCDE, 1, 0, 0, 3};
    applyStimulus(v);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
